// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one 8x8 multiplier between two
// requesters, with per-port response handshakes and a WAIT-state watchdog.
module mul_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [15:0] req0_ba,
    input  logic [15:0] req1_ba,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [15:0] resp_prod,
    output logic        resp_err,
    output logic        mul_start,
    output logic [15:0] mul_ip_BA,
    input  logic [15:0] mul_op_prod,
    input  logic        mul_ready,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ba_q, ba_d;
    logic [15:0] prod_q, prod_d;
    logic        err_q, err_d;
    logic [15:0] op_count_q, op_count_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic winner;
    logic accept;
    logic resp_hs;
    logic timeout_hit;

    // On a tie the port that did not win last time gets the grant.
    assign winner      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready  = reset && (state_q == S_IDLE) && req0_valid && !winner;
    assign req1_ready  = reset && (state_q == S_IDLE) && req1_valid && winner;
    assign accept      = req0_ready || req1_ready;
    assign mul_start   = (state_q == S_ISSUE) && mul_ready;
    assign resp0_valid = (state_q == S_RESP) && !grant_q;
    assign resp1_valid = (state_q == S_RESP) && grant_q;
    assign resp_hs     = (state_q == S_RESP) && (grant_q ? resp1_ready : resp0_ready);
    assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));

    assign busy      = (state_q != S_IDLE);
    assign grant_id  = grant_q;
    assign mul_ip_BA = ba_q;
    assign resp_prod = prod_q;
    assign resp_err  = err_q;
    assign op_count  = op_count_q;

    always_comb begin
        state_d      = state_q;
        ba_d         = ba_q;
        prod_d       = prod_q;
        err_d        = err_q;
        op_count_d   = op_count_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ba_d         = winner ? req1_ba : req0_ba;
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mul_ready) begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (mul_ready) begin
                    prod_d  = mul_op_prod;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    // Forced completion: whatever the multiplier holds is returned, flagged.
                    prod_d  = mul_op_prod;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_hs) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ba_q         <= 16'd0;
            prod_q       <= 16'd0;
            err_q        <= 1'b0;
            op_count_q   <= 16'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            ba_q         <= ba_d;
            prod_q       <= prod_d;
            err_q        <= err_d;
            op_count_q   <= op_count_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a small registered multiplier model.
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_ba, req1_ba;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [15:0] resp_prod;
    logic        resp_err;
    logic        mul_start;
    logic [15:0] mul_ip_BA;
    logic [15:0] mul_op_prod;
    logic        mul_ready;
    logic        busy;
    logic        grant_id;
    logic [15:0] op_count;

    logic        m_rdy_q;
    logic [15:0] m_prod_q;
    logic        force_low;

    int checks = 0;
    int errors = 0;

    mul_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ba(req0_ba), .req1_ba(req1_ba),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_prod(resp_prod), .resp_err(resp_err),
        .mul_start(mul_start), .mul_ip_BA(mul_ip_BA),
        .mul_op_prod(mul_op_prod), .mul_ready(mul_ready),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Multiplier model: product registered on start, ready low the cycle after a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rdy_q  <= 1'b1;
            m_prod_q <= 16'd0;
        end else begin
            m_rdy_q <= ~mul_start;
            if (mul_start) m_prod_q <= 16'(mul_ip_BA[15:8]) * 16'(mul_ip_BA[7:0]);
        end
    end
    assign mul_ready   = m_rdy_q & ~force_low;
    assign mul_op_prod = m_prod_q;

    task automatic wait_resp(input int port, output int cyc);
        cyc = 0;
        while (!((port != 0) ? resp1_valid : resp0_valid) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; force_low = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_ba = 16'h0203; req1_ba = 16'h0407;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b want 00", req0_ready, req1_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", mul_start); end
        checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_respv got %0b%0b want 00", resp0_valid, resp1_valid); end
        checks++; if (op_count !== 16'h0000 || grant_id !== 1'b0) begin errors++; $display("FAIL reset_cnt got %h/%0b want 0000/0", op_count, grant_id); end
        checks++; if (mul_ip_BA !== 16'h0000 || resp_prod !== 16'h0000 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%h/%0b want 0", mul_ip_BA, resp_prod, resp_err); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc;
        req0_ba = 16'h0305; req0_valid = 1'b1; #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_accept got %0b%0b want 10", req0_ready, req1_ready); end
        @(negedge clk); req0_valid = 1'b0;
        checks++; if (mul_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue start=%0b busy=%0b want 1/1", mul_start, busy); end
        checks++; if (mul_ip_BA !== 16'h0305 || grant_id !== 1'b0) begin errors++; $display("FAIL single_ba got %h/%0b want 0305/0", mul_ip_BA, grant_id); end
        @(negedge clk);
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got %0b want 0", mul_start); end
        wait_resp(0, cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL single_latency got %0d want 2 more cycles", cyc); end
        checks++; if (resp_prod !== 16'h000F || resp_err !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL single_resp got %h/%0b/%0b want 000F/0/0", resp_prod, resp_err, resp1_valid); end
        resp0_ready = 1'b1;
        @(negedge clk); resp0_ready = 1'b0;
        checks++; if (busy !== 1'b0 || resp0_valid !== 1'b0 || op_count !== 16'd1) begin errors++; $display("FAIL single_done busy=%0b v=%0b cnt=%h want 0/0/0001", busy, resp0_valid, op_count); end
    endtask

    task automatic test_tie();
        int cyc;
        int exp_port [3] = '{0, 1, 0};
        reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
        req0_ba = 16'h0203; req1_ba = 16'h0407;
        req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req0_ready !== (exp_port[k] == 0) || req1_ready !== (exp_port[k] == 1)) begin errors++; $display("FAIL tie_ready%0d got %0b%0b want port %0d", k, req0_ready, req1_ready, exp_port[k]); end
            @(negedge clk);
            checks++; if (grant_id !== 1'(exp_port[k])) begin errors++; $display("FAIL tie_grant%0d got %0b want %0d", k, grant_id, exp_port[k]); end
            wait_resp(exp_port[k], cyc);
            checks++; if (cyc != 3) begin errors++; $display("FAIL tie_latency%0d got %0d want 3", k, cyc); end
            checks++; if (resp_prod !== ((exp_port[k] != 0) ? 16'h001C : 16'h0006)) begin errors++; $display("FAIL tie_prod%0d got %h", k, resp_prod); end
            if (k == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || op_count !== 16'd3) begin errors++; $display("FAIL tie_done busy=%0b cnt=%h want 0/0003", busy, op_count); end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        req0_ba = 16'h0A0B; req1_ba = 16'h0407;
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %0b%0b want 01", req0_ready, req1_ready); end
        @(negedge clk); req1_valid = 1'b0;
        wait_resp(1, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL bp_latency got %0d want 3", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (resp1_valid !== 1'b1 || resp_prod !== 16'h001C || resp_err !== 1'b0 || req0_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d v=%0b prod=%h err=%0b r0=%0b busy=%0b want 1/001C/0/0/1", i, resp1_valid, resp_prod, resp_err, req0_ready, busy);
            end
        end
        resp1_ready = 1'b1;
        @(negedge clk); resp1_ready = 1'b0; #1;
        checks++; if (req0_ready !== 1'b1 || resp1_valid !== 1'b0 || op_count !== 16'd4) begin errors++; $display("FAIL bp_next r0=%0b v1=%0b cnt=%h want 1/0/0004", req0_ready, resp1_valid, op_count); end
        @(negedge clk); req0_valid = 1'b0;
        checks++; if (grant_id !== 1'b0 || mul_ip_BA !== 16'h0A0B) begin errors++; $display("FAIL bp_grant0 got %0b/%h want 0/0A0B", grant_id, mul_ip_BA); end
        wait_resp(0, cyc);
        checks++; if (resp_prod !== 16'h006E) begin errors++; $display("FAIL bp_prod0 got %h want 006E", resp_prod); end
        resp0_ready = 1'b1;
        @(negedge clk); resp0_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc;
        req0_ba = 16'h0506; req0_valid = 1'b1; #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL to_accept got %0b want 1", req0_ready); end
        @(negedge clk); req0_valid = 1'b0;
        checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL to_start got %0b want 1", mul_start); end
        @(negedge clk); force_low = 1'b1;
        wait_resp(0, cyc);
        checks++; if (cyc != 15) begin errors++; $display("FAIL to_latency got %0d want 15", cyc); end
        checks++; if (resp_err !== 1'b1 || resp_prod !== 16'h001E || busy !== 1'b1) begin errors++; $display("FAIL to_resp err=%0b prod=%h busy=%0b want 1/001E/1", resp_err, resp_prod, busy); end
        resp0_ready = 1'b1; force_low = 1'b0;
        @(negedge clk); resp0_ready = 1'b0;
        checks++; if (busy !== 1'b0 || op_count !== 16'd6) begin errors++; $display("FAIL to_done busy=%0b cnt=%h want 0/0006", busy, op_count); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        req1_ba = 16'h0102; req1_valid = 1'b1;
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL rst_pre busy=%0b grant=%0b want 1/1", busy, grant_id); end
        req0_ba = 16'h0203; req1_ba = 16'h0407; req0_valid = 1'b1; req1_valid = 1'b1;
        reset = 1'b0; #1;
        checks++; if (busy !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL rst_ctrl busy=%0b start=%0b want 0/0", busy, mul_start); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_hs got %0b%0b%0b%0b want 0000", req0_ready, req1_ready, resp0_valid, resp1_valid); end
        checks++; if (mul_ip_BA !== 16'h0 || resp_prod !== 16'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_data got %h/%h/%0b want 0", mul_ip_BA, resp_prod, resp_err); end
        checks++; if (op_count !== 16'h0 || grant_id !== 1'b0) begin errors++; $display("FAIL rst_cnt got %h/%0b want 0000/0", op_count, grant_id); end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_tie got %0b%0b want 10", req0_ready, req1_ready); end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(0, cyc);
        checks++; if (resp0_valid !== 1'b1 || resp_prod !== 16'h0006) begin errors++; $display("FAIL rst_op v=%0b prod=%h want 1/0006", resp0_valid, resp_prod); end
        resp0_ready = 1'b1;
        @(negedge clk); resp0_ready = 1'b0;
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_cnt_after got %h want 0001", op_count); end
    endtask

    task automatic test_wrap();
        int cyc;
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        req1_ba = 16'hFFFF; req1_valid = 1'b1; #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL wrap_accept got %0b want 1", req1_ready); end
        @(negedge clk); req1_valid = 1'b0;
        wait_resp(1, cyc);
        checks++; if (resp_prod !== 16'hFE01 || resp_err !== 1'b0) begin errors++; $display("FAIL wrap_prod got %h/%0b want FE01/0", resp_prod, resp_err); end
        checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want FFFF", op_count); end
        resp1_ready = 1'b1;
        @(negedge clk); resp1_ready = 1'b0;
        checks++; if (op_count !== 16'h0000 || resp1_valid !== 1'b0) begin errors++; $display("FAIL wrap_cnt got %h/%0b want 0000/0", op_count, resp1_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
